// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the HI/LO multiply/divide controller.
//   md_op_t    : E-stage operation codes (MD_NONE means idle)
//   md_state_t : controller states
//   default latency constants and an op-class helper
package md_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_t;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    // True for the ops that occupy the unit for several cycles.
    function automatic logic is_arith_op(input md_op_t op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_unit_ctrl_if.sv
// md_unit_ctrl_if: E-stage <-> mult/div unit signal bundle.
//   master : pipeline side (drives op, operands, cancel, read select, D-stage use)
//   slave  : md unit (drives busy, start, stall_md, hi, lo, md_out)
interface md_unit_ctrl_if;
    import md_pkg::*;

    md_op_t      md_op;
    logic        cancel;
    logic [31:0] rs_e;
    logic [31:0] rt_e;
    logic        rd_hi;
    logic        d_uses_md;
    logic        busy;
    logic        start;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_out;

    modport master (
        output md_op, cancel, rs_e, rt_e, rd_hi, d_uses_md,
        input  busy, start, stall_md, hi, lo, md_out
    );

    modport slave (
        input  md_op, cancel, rs_e, rt_e, rd_hi, d_uses_md,
        output busy, start, stall_md, hi, lo, md_out
    );

endinterface

// File: rtl/md_arith.sv
// md_arith: combinational multiply/divide datapath.
//   i_op   : operation (only MULT/MULTU/DIV/DIVU are meaningful)
//   i_a    : operand A (rs), i_b : operand B (rt)
//   o_res  : {hi, lo}; mult -> product, div -> {remainder, quotient}
//   o_dz   : divide op with zero divisor
module md_arith
    import md_pkg::*;
(
    input  md_op_t      i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [63:0] o_res,
    output logic        o_dz
);

    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    logic               w_sgn_div;
    logic               w_neg_a;
    logic               w_neg_b;
    logic        [31:0] w_mag_a;
    logic        [31:0] w_mag_b;
    logic        [31:0] w_q_mag;
    logic        [31:0] w_r_mag;
    logic        [31:0] w_q;
    logic        [31:0] w_r;

    assign w_prod_s = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
    assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

    // Signed divide runs on magnitudes and fixes signs afterwards: this keeps
    // 0x80000000 / -1 well defined (quotient wraps to 0x80000000, remainder 0).
    assign w_sgn_div = (i_op == MD_DIV);
    assign w_neg_a   = w_sgn_div & i_a[31];
    assign w_neg_b   = w_sgn_div & i_b[31];
    assign w_mag_a   = w_neg_a ? (32'd0 - i_a) : i_a;
    assign w_mag_b   = w_neg_b ? (32'd0 - i_b) : i_b;
    assign w_q_mag   = w_mag_a / w_mag_b;
    assign w_r_mag   = w_mag_a % w_mag_b;
    assign w_q       = (w_neg_a ^ w_neg_b) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_r       = w_neg_a ? (32'd0 - w_r_mag) : w_r_mag;   // remainder takes dividend's sign

    assign o_dz = ((i_op == MD_DIV) || (i_op == MD_DIVU)) && (i_b == 32'd0);

    always_comb begin
        o_res = 64'd0;
        case (i_op)
            MD_MULT:          o_res = w_prod_s;
            MD_MULTU:         o_res = w_prod_u;
            MD_DIV, MD_DIVU:  o_res = {w_r, w_q};
            default:          o_res = 64'd0;
        endcase
    end

endmodule

// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: EX-stage sequencer for the shared HI/LO mult/div unit.
//   i_clk, i_reset : clock, synchronous active-high reset
//   bus (slave)    : md_op/cancel/rs_e/rt_e/rd_hi/d_uses_md in;
//                    busy/start/stall_md/hi/lo/md_out out
// A mult/div result is computed at the start edge, held in pending registers,
// and committed to HI/LO exactly MULT_CYCLES / DIV_CYCLES edges later.
module md_unit_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic           i_clk,
    input  logic           i_reset,
    md_unit_ctrl_if.slave  bus
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    md_state_t   r_state;
    logic [CW-1:0] r_count;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;
    logic        r_pend_dz;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;

    logic [63:0] w_res;
    logic        w_dz;
    logic        w_start;
    logic        w_is_mult;

    md_arith u_arith (
        .i_op  (bus.md_op),
        .i_a   (bus.rs_e),
        .i_b   (bus.rt_e),
        .o_res (w_res),
        .o_dz  (w_dz)
    );

    assign w_start   = is_arith_op(bus.md_op) & ~bus.cancel;
    assign w_is_mult = (bus.md_op == MD_MULT) || (bus.md_op == MD_MULTU);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_pend_dz <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_pend_hi <= w_res[63:32];
                        r_pend_lo <= w_res[31:0];
                        r_pend_dz <= w_dz;
                        r_count   <= w_is_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                        r_busy    <= 1'b1;
                        r_state   <= ST_BUSY;
                    end else if (!bus.cancel) begin
                        if (bus.md_op == MD_MTHI) r_hi <= bus.rs_e;
                        if (bus.md_op == MD_MTLO) r_lo <= bus.rs_e;
                    end
                end
                ST_BUSY: begin
                    // Incoming md_op is ignored here; the stall keeps it in D.
                    if (r_count == CW'(1)) begin
                        if (!r_pend_dz) begin
                            r_hi <= r_pend_hi;
                            r_lo <= r_pend_lo;
                        end
                        r_count <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_count <= r_count - CW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.start    = w_start;
    assign bus.stall_md = bus.d_uses_md & (w_start | r_busy);
    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;
    assign bus.md_out   = bus.rd_hi ? r_hi : r_lo;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// tb_md_unit_ctrl: directed bench for md_unit_ctrl. A cycle-stamped model
// (commit scheduled at start cycle + latency, results by plain integer
// arithmetic) is compared against every output on every falling edge after
// reset; literal expectations pin the model on the test-plan vectors.
module tb_md_unit_ctrl;
    import md_pkg::*;

    logic clk = 1'b0;
    logic reset;
    md_unit_ctrl_if u_if ();

    md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (u_if)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_en = 1'b0;
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    logic        m_pend = 1'b0;
    logic        m_dz;
    int          cyc = 0;
    int          m_at = 0;

    task automatic model_calc(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                              output logic [31:0] rhi, output logic [31:0] rlo, output logic dz);
        longint          sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        dz = 1'b0;
        rhi = 32'd0;
        rlo = 32'd0;
        case (op)
            MD_MULT:  begin sp = sa * sb; rhi = sp[63:32]; rlo = sp[31:0]; end
            MD_MULTU: begin up = ua * ub; rhi = up[63:32]; rlo = up[31:0]; end
            MD_DIV: begin
                if (b == 32'd0) dz = 1'b1;
                else begin sq = sa / sb; sr = sa % sb; rlo = sq[31:0]; rhi = sr[31:0]; end
            end
            MD_DIVU: begin
                if (b == 32'd0) dz = 1'b1;
                else begin uq = ua / ub; ur = ua % ub; rlo = uq[31:0]; rhi = ur[31:0]; end
            end
            default: ;
        endcase
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        if (reset) begin
            m_en = 1'b1; m_hi = 0; m_lo = 0; m_pend = 1'b0;
        end else if (m_pend) begin
            if (cyc == m_at) begin
                m_pend = 1'b0;
                if (!m_dz) begin m_hi = m_phi; m_lo = m_plo; end
            end
        end else if (!u_if.cancel) begin
            case (u_if.md_op)
                MD_MULT, MD_MULTU: begin
                    model_calc(u_if.md_op, u_if.rs_e, u_if.rt_e, m_phi, m_plo, m_dz);
                    m_pend = 1'b1; m_at = cyc + 5;
                end
                MD_DIV, MD_DIVU: begin
                    model_calc(u_if.md_op, u_if.rs_e, u_if.rt_e, m_phi, m_plo, m_dz);
                    m_pend = 1'b1; m_at = cyc + 10;
                end
                MD_MTHI: m_hi = u_if.rs_e;
                MD_MTLO: m_lo = u_if.rs_e;
                default: ;
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        logic e_start;
        @(negedge clk);
        if (m_en && !reset) begin
            e_start = (u_if.md_op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU}) && !u_if.cancel;
            check("busy",     {31'd0, u_if.busy},     {31'd0, m_pend});
            check("start",    {31'd0, u_if.start},    {31'd0, e_start});
            check("stall_md", {31'd0, u_if.stall_md}, {31'd0, u_if.d_uses_md && (e_start || m_pend)});
            check("hi",       u_if.hi,                m_hi);
            check("lo",       u_if.lo,                m_lo);
            check("md_out",   u_if.md_out,            u_if.rd_hi ? m_hi : m_lo);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input md_op_t op, input logic [31:0] a, input logic [31:0] b, input logic c);
        @(posedge clk);
        #1;
        u_if.md_op  = op;
        u_if.rs_e   = a;
        u_if.rt_e   = b;
        u_if.cancel = c;
        u_if.rd_hi  = ~u_if.rd_hi;
    endtask

    // Issue one op, then idle 14 cycles counting busy and stall cycles
    // (the first sample is the issue cycle itself).
    task automatic run_op(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                          input logic c, output int bc, output int sc);
        bc = 0;
        sc = 0;
        drive(op, a, b, c);
        repeat (14) begin
            @(negedge clk);
            bc += int'(u_if.busy);
            sc += int'(u_if.stall_md);
            drive(MD_NONE, 32'd0, 32'd0, 1'b0);
        end
    endtask

    initial begin
        int bc, sc;
        reset          = 1'b1;
        u_if.md_op     = MD_NONE;
        u_if.cancel    = 1'b0;
        u_if.rs_e      = 32'd0;
        u_if.rt_e      = 32'd0;
        u_if.rd_hi     = 1'b0;
        u_if.d_uses_md = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_hi",   u_if.hi, 32'd0);
        check("reset_lo",   u_if.lo, 32'd0);
        check("reset_busy", {31'd0, u_if.busy}, 32'd0);

        run_op(MD_MULT, 32'hFFFFFFFF, 32'd2, 1'b0, bc, sc);
        check("mult_busy_cycles", bc, 5);
        check("mult_hi", u_if.hi, 32'hFFFFFFFF);
        check("mult_lo", u_if.lo, 32'hFFFFFFFE);

        run_op(MD_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0, bc, sc);
        check("multu_busy_cycles", bc, 5);
        check("multu_hi", u_if.hi, 32'h00000001);
        check("multu_lo", u_if.lo, 32'hFFFFFFFE);

        run_op(MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, bc, sc);
        check("div_busy_cycles", bc, 10);
        check("div_lo", u_if.lo, 32'hFFFFFFFD);
        check("div_hi", u_if.hi, 32'hFFFFFFFF);

        run_op(MD_DIVU, 32'd7, 32'd2, 1'b0, bc, sc);
        check("divu_lo", u_if.lo, 32'd3);
        check("divu_hi", u_if.hi, 32'd1);

        run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, bc, sc);
        check("div_ovf_lo", u_if.lo, 32'h80000000);
        check("div_ovf_hi", u_if.hi, 32'd0);

        // divide by zero leaves HI/LO alone but still takes the full latency
        drive(MD_MTHI, 32'h1234, 32'd0, 1'b0);
        drive(MD_MTLO, 32'h5678, 32'd0, 1'b0);
        drive(MD_NONE, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        check("mthi_val", u_if.hi, 32'h1234);
        run_op(MD_DIV, 32'd99, 32'd0, 1'b0, bc, sc);
        check("dz_busy_cycles", bc, 10);
        check("dz_hi", u_if.hi, 32'h1234);
        check("dz_lo", u_if.lo, 32'h5678);

        // stall window: start cycle plus all busy cycles
        u_if.d_uses_md = 1'b1;
        run_op(MD_MULT, 32'd3, 32'd5, 1'b0, bc, sc);
        check("stall_cycles", sc, 6);
        check("mult35_lo", u_if.lo, 32'd15);
        u_if.d_uses_md = 1'b0;
        run_op(MD_MULT, 32'd2, 32'd3, 1'b0, bc, sc);
        check("no_stall_cycles", sc, 0);

        // cancelled ops have no effect
        run_op(MD_MULT, 32'd9, 32'd9, 1'b1, bc, sc);
        check("cancel_mult_busy", bc, 0);
        check("cancel_mult_lo", u_if.lo, 32'd6);
        drive(MD_MTHI, 32'h77, 32'd0, 1'b0);
        drive(MD_MTHI, 32'hAAAA0000, 32'd0, 1'b1);
        drive(MD_NONE, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        check("cancel_mthi_hi", u_if.hi, 32'h77);

        drive(MD_MTLO, 32'h55, 32'd0, 1'b0);
        drive(MD_NONE, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        check("mtlo_lo", u_if.lo, 32'h55);
        check("mtlo_busy", {31'd0, u_if.busy}, 32'd0);

        // reset in busy cycle 4 of a divide abandons it
        drive(MD_DIV, 32'd100, 32'd7, 1'b0);
        repeat (4) drive(MD_NONE, 32'd0, 32'd0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_mid_busy", {31'd0, u_if.busy}, 32'd0);
        check("rst_mid_hi", u_if.hi, 32'd0);
        check("rst_mid_lo", u_if.lo, 32'd0);
        repeat (12) @(negedge clk);
        check("rst_no_commit_hi", u_if.hi, 32'd0);
        check("rst_no_commit_lo", u_if.lo, 32'd0);

        run_op(MD_MULT, 32'd3, 32'd4, 1'b0, bc, sc);
        check("post_rst_busy_cycles", bc, 5);
        check("post_rst_lo", u_if.lo, 32'd12);
        check("post_rst_hi", u_if.hi, 32'd0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
